// File: rtl/code_entry_pkg.sv
// Shared constants for the code entry controller: FSM state encodings and default code width.
package code_entry_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_ENTRY    = 2'd0;
  localparam logic [1:0] ST_CHECK    = 2'd1;
  localparam logic [1:0] ST_FALLBACK = 2'd2;
  localparam logic [1:0] ST_MATCH    = 2'd3;

endpackage

// File: rtl/button_edge.sv
// Two-flop synchroniser for an active-low raw key plus a registered one-cycle strobe on its falling edge.
module button_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic strobe
);

  logic [2:0] sync_r;
  logic       strobe_r;

  // sync_r[1] is the synchronised level, sync_r[2] its previous value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r   <= 3'b111;
      strobe_r <= 1'b0;
    end else begin
      sync_r   <= {sync_r[1:0], button};
      strobe_r <= sync_r[2] & ~sync_r[1];
    end
  end

  assign strobe = strobe_r;

endmodule

// File: rtl/code_entry_ctrl.sv
// Two-button serial code entry with prefix checking, longest-suffix fallback on mismatch and timed LEDs.
module code_entry_ctrl
  import code_entry_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int LED_TIME = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] switch,
  input  logic             button0,
  input  logic             button1,
  output logic [WIDTH-1:0] type_in,
  output logic [3:0]       count,
  output logic             led_g,
  output logic             led_r,
  output logic             busy
);

  localparam int               TW         = ($clog2(LED_TIME + 1) < 1) ? 1 : $clog2(LED_TIME + 1);
  localparam logic [TW-1:0]    TIMER_LOAD = (LED_TIME < 1) ? TW'(1) : TW'(LED_TIME);
  localparam logic [TW-1:0]    TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0]    TIMER_ZERO = TW'(0);
  localparam logic [3:0]       WIDTH_C    = 4'(WIDTH);
  localparam logic [WIDTH-1:0] ONES       = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MSB        = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] top_mask(input logic [3:0] n);
    return ~(ONES >> n);
  endfunction

  logic             strobe0_s, strobe1_s, one_strobe_s;
  logic [1:0]       state_r, state_nxt_s;
  logic [WIDTH-1:0] target_r, target_nxt_s;
  logic [WIDTH-1:0] type_in_r, type_in_nxt_s;
  logic [3:0]       count_r, count_nxt_s;
  logic [3:0]       fb_len_r, fb_len_nxt_s;
  logic [TW-1:0]    timer_r, timer_nxt_s;
  logic             led_g_r, led_g_nxt_s;
  logic             led_r_r, led_r_nxt_s;
  logic             busy_r;
  logic             expire_s;
  logic [WIDTH-1:0] bit_mask_s, fb_cand_s;

  button_edge u_edge0 (.clk(clk), .rst_n(rst_n), .button(button0), .strobe(strobe0_s));
  button_edge u_edge1 (.clk(clk), .rst_n(rst_n), .button(button1), .strobe(strobe1_s));

  assign one_strobe_s = strobe0_s ^ strobe1_s;
  assign expire_s     = (timer_r == TIMER_ONE);
  assign bit_mask_s   = MSB >> count_r;
  // the last fb_len_r entered bits, moved up to the MSB end with zeros below
  assign fb_cand_s    = type_in_r << (count_r - fb_len_r);

  // Next-state logic: LED timer, FSM, then enable overriding everything
  always_comb begin
    state_nxt_s   = state_r;
    target_nxt_s  = target_r;
    type_in_nxt_s = type_in_r;
    count_nxt_s   = count_r;
    fb_len_nxt_s  = fb_len_r;
    led_g_nxt_s   = led_g_r;
    led_r_nxt_s   = led_r_r;
    if (timer_r != TIMER_ZERO) begin
      timer_nxt_s = timer_r - TIMER_ONE;
    end else begin
      timer_nxt_s = timer_r;
    end
    if (expire_s) begin
      led_g_nxt_s = 1'b0;
      led_r_nxt_s = 1'b0;
    end else begin
      led_g_nxt_s = led_g_r;
      led_r_nxt_s = led_r_r;
    end

    case (state_r)
      ST_ENTRY: begin
        if (one_strobe_s && (count_r < WIDTH_C)) begin
          type_in_nxt_s = strobe1_s ? (type_in_r | bit_mask_s) : (type_in_r & ~bit_mask_s);
          count_nxt_s   = count_r + 4'd1;
          state_nxt_s   = ST_CHECK;
        end else begin
          state_nxt_s = ST_ENTRY;
        end
      end
      ST_CHECK: begin
        if ((type_in_r & top_mask(count_r)) == (target_r & top_mask(count_r))) begin
          if (count_r == WIDTH_C) begin
            state_nxt_s = ST_MATCH;
            led_g_nxt_s = 1'b1;
            timer_nxt_s = TIMER_LOAD;
          end else begin
            state_nxt_s = ST_ENTRY;
          end
        end else begin
          state_nxt_s  = ST_FALLBACK;
          led_r_nxt_s  = 1'b1;
          timer_nxt_s  = TIMER_LOAD;
          fb_len_nxt_s = count_r - 4'd1;
        end
      end
      ST_FALLBACK: begin
        if ((fb_len_r == 4'd0) || (fb_cand_s == (target_r & top_mask(fb_len_r)))) begin
          type_in_nxt_s = fb_cand_s;
          count_nxt_s   = fb_len_r;
          state_nxt_s   = ST_ENTRY;
        end else begin
          fb_len_nxt_s = fb_len_r - 4'd1;
        end
      end
      ST_MATCH: begin
        if (expire_s) begin
          type_in_nxt_s = {WIDTH{1'b0}};
          count_nxt_s   = 4'd0;
          state_nxt_s   = ST_ENTRY;
        end else begin
          state_nxt_s = ST_MATCH;
        end
      end
      default: begin
        state_nxt_s = ST_ENTRY;
      end
    endcase

    if (enable) begin
      target_nxt_s  = switch;
      type_in_nxt_s = {WIDTH{1'b0}};
      count_nxt_s   = 4'd0;
      fb_len_nxt_s  = 4'd0;
      led_g_nxt_s   = 1'b0;
      led_r_nxt_s   = 1'b0;
      timer_nxt_s   = TIMER_ZERO;
      state_nxt_s   = ST_ENTRY;
    end else begin
      target_nxt_s = target_nxt_s;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_ENTRY;
      target_r  <= {WIDTH{1'b0}};
      type_in_r <= {WIDTH{1'b0}};
      count_r   <= 4'd0;
      fb_len_r  <= 4'd0;
      timer_r   <= TIMER_ZERO;
      led_g_r   <= 1'b0;
      led_r_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      target_r  <= target_nxt_s;
      type_in_r <= type_in_nxt_s;
      count_r   <= count_nxt_s;
      fb_len_r  <= fb_len_nxt_s;
      timer_r   <= timer_nxt_s;
      led_g_r   <= led_g_nxt_s;
      led_r_r   <= led_r_nxt_s;
      busy_r    <= (state_nxt_s == ST_FALLBACK) || (state_nxt_s == ST_MATCH);
    end
  end

  assign type_in = type_in_r;
  assign count   = count_r;
  assign led_g   = led_g_r;
  assign led_r   = led_r_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Scoreboard bench for code_entry_ctrl: a reference model predicts the outcome of every press.
module tb_code_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] switch;
  logic       button0, button1;
  logic [7:0] type_in;
  logic [3:0] count;
  logic       led_g, led_r, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] t;
    logic [3:0] c;
    int         busy_cyc;
    bit         chk_r;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_tgt;
  logic [7:0] m_type;
  int         m_count;
  int         last_g, last_r;
  logic [7:0] cap_t;
  logic [3:0] cap_c;

  code_entry_ctrl #(.WIDTH(8), .LED_TIME(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .switch(switch),
    .button0(button0), .button1(button1), .type_in(type_in), .count(count),
    .led_g(led_g), .led_r(led_r), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: append the bit, then either accept the prefix, match, or find the longest suffix
  task automatic model_press(input bit b, input bit full);
    exp_t       e;
    logic [7:0] t, nt;
    int         n;
    bit         eq, hit;
    t = m_type;
    n = m_count;
    t[7-n] = b;
    n = n + 1;
    eq = 1'b1;
    for (int k = 0; k < n; k++) if (t[7-k] !== m_tgt[7-k]) eq = 1'b0;
    e.chk_r = 1'b0;
    if (eq && n == 8) begin
      e.t = full ? 8'h00 : t;
      e.c = full ? 4'd0 : 4'd8;
      e.busy_cyc = full ? 16 : 1;
      m_type = 8'h00;
      m_count = 0;
    end else if (eq) begin
      e.t = t;
      e.c = 4'(n);
      e.busy_cyc = 0;
      m_type = t;
      m_count = n;
    end else begin
      e.chk_r = !full;
      for (int L = n - 1; L >= 0; L--) begin
        hit = 1'b1;
        for (int j = 0; j < L; j++) if (t[7-(n-L+j)] !== m_tgt[7-j]) hit = 1'b0;
        if (hit) begin
          nt = 8'h00;
          for (int j = 0; j < L; j++) nt[7-j] = t[7-(n-L+j)];
          m_type = nt;
          m_count = L;
          e.busy_cyc = n - L;
          break;
        end
      end
      e.t = m_type;
      e.c = 4'(m_count);
    end
    sb.push_back(e);
  endtask

  task automatic drive_press(input bit b);
    if (b) button1 = 1'b0; else button0 = 1'b0;
    repeat (3) tick();
    button0 = 1'b1;
    button1 = 1'b1;
  endtask

  // One press: predict, drive, wait for the DUT to settle, then pop and compare
  task automatic press(input bit b, input bit full);
    exp_t e;
    int   gc, rc, bc;
    bit   done, seen;
    model_press(b, full);
    drive_press(b);
    gc = 0; rc = 0; bc = 0; done = 1'b0; seen = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      gc = gc + (led_g ? 1 : 0);
      rc = rc + (led_r ? 1 : 0);
      bc = bc + (busy ? 1 : 0);
      if (led_g && !seen) begin
        cap_t = type_in;
        cap_c = count;
        seen = 1'b1;
      end
      if (i >= 1 && (full ? (!busy && !led_g && !led_r) : (!busy || led_g))) done = 1'b1;
    end
    last_g = gc;
    last_r = rc;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL press_settle: DUT did not settle within 40 cycles");
    end
    e = sb.pop_front();
    checks++;
    if (type_in !== e.t) begin
      errors++;
      $display("FAIL press_type_in: got %h expected %h", type_in, e.t);
    end
    checks++;
    if (count !== e.c) begin
      errors++;
      $display("FAIL press_count: got %0d expected %0d", count, e.c);
    end
    checks++;
    if (bc !== e.busy_cyc) begin
      errors++;
      $display("FAIL press_busy_cycles: got %0d expected %0d", bc, e.busy_cyc);
    end
    if (e.chk_r) begin
      checks++;
      if (led_r !== 1'b1) begin
        errors++;
        $display("FAIL press_led_r: got %b expected 1", led_r);
      end
    end
  endtask

  task automatic load_target(input logic [7:0] v);
    switch = v;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    m_tgt = v;
    m_type = 8'h00;
    m_count = 0;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (type_in !== 8'h00 || count !== 4'd0 || led_g !== 1'b0 || led_r !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got type_in=%h count=%0d led_g=%b led_r=%b busy=%b expected all 0",
               name, type_in, count, led_g, led_r, busy);
    end
  endtask

  task automatic press_prefix7();
    press(1'b1, 1'b0); press(1'b0, 1'b0); press(1'b1, 1'b0); press(1'b0, 1'b0);
    press(1'b0, 1'b0); press(1'b1, 1'b0); press(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; switch = 8'h00; button0 = 1'b1; button1 = 1'b1;
    m_tgt = 8'h00; m_type = 8'h00; m_count = 0;
    #12;
    check_idle("reset_state");
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_match();
    load_target(8'hA5);
    press_prefix7();
    press(1'b1, 1'b1);
    checks++;
    if (cap_t !== 8'hA5 || cap_c !== 4'd8) begin
      errors++;
      $display("FAIL match_hold: got type_in=%h count=%0d expected a5/8", cap_t, cap_c);
    end
    checks++;
    if (last_g !== 16) begin
      errors++;
      $display("FAIL match_led_g_len: got %0d expected 16", last_g);
    end
  endtask

  task automatic test_fallback();
    load_target(8'hA5);
    press(1'b1, 1'b0); press(1'b0, 1'b0); press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    checks++;
    if (last_r !== 16) begin
      errors++;
      $display("FAIL fallback_led_r_len: got %0d expected 16", last_r);
    end
  endtask

  task automatic test_empty_zero();
    load_target(8'hA5);
    press(1'b0, 1'b0);
  endtask

  task automatic test_simultaneous();
    exp_t e;
    load_target(8'hA5);
    press(1'b1, 1'b0);
    e.t = m_type; e.c = 4'(m_count); e.busy_cyc = 0; e.chk_r = 1'b0;
    sb.push_back(e);
    button0 = 1'b0;
    button1 = 1'b0;
    repeat (3) tick();
    button0 = 1'b1;
    button1 = 1'b1;
    repeat (4) tick();
    e = sb.pop_front();
    checks++;
    if (type_in !== e.t || count !== e.c || busy !== 1'b0) begin
      errors++;
      $display("FAIL simultaneous: got type_in=%h count=%0d busy=%b expected %h/%0d/0",
               type_in, count, busy, e.t, e.c);
    end
  endtask

  task automatic test_ignore_in_match();
    bit gone;
    load_target(8'hA5);
    press_prefix7();
    press(1'b1, 1'b0);
    drive_press(1'b0);
    repeat (3) tick();
    checks++;
    if (type_in !== 8'hA5 || count !== 4'd8 || led_g !== 1'b1) begin
      errors++;
      $display("FAIL match_ignore: got type_in=%h count=%0d led_g=%b expected a5/8/1", type_in, count, led_g);
    end
    gone = 1'b0;
    for (int i = 0; i < 30 && !gone; i++) begin
      tick();
      if (!led_g) gone = 1'b1;
    end
    check_idle("match_expiry");
  endtask

  task automatic test_enable_fallback();
    load_target(8'hA5);
    press(1'b1, 1'b0); press(1'b0, 1'b0); press(1'b1, 1'b0);
    drive_press(1'b1);
    repeat (2) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL enable_pre_fallback: got busy=%b expected 1", busy);
    end
    load_target(8'hA5);
    repeat (10) tick();
    check_idle("enable_mid_fallback");
    press(1'b1, 1'b0);
  endtask

  task automatic test_reset_match();
    load_target(8'hA5);
    press_prefix7();
    press(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("reset_async_mid_match");
    repeat (2) tick();
    rst_n = 1'b1;
    m_tgt = 8'h00; m_type = 8'h00; m_count = 0;
    repeat (20) tick();
    check_idle("reset_release_after_match");
    press(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_match();
    test_fallback();
    test_empty_zero();
    test_simultaneous();
    test_ignore_in_match();
    test_enable_fallback();
    test_reset_match();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
